// File: rtl/led_nibble_sequencer.sv
// LED nibble sequencer: buffers received nibbles in a small circular FIFO and
// shows each one on the LEDs for a fixed number of clock cycles, back-to-back
// while more are queued. A sticky flag records nibbles dropped on a full FIFO.
module led_nibble_sequencer #(
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    rx_data,
    input  logic                          rx_done,
    input  logic                          ovf_clear,
    output logic [3:0]                    led,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(HOLD_CYCLES);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [PtrW:0]   DepthVal = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic {StIdle, StShow} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic [CntW-1:0]   hold_q, hold_d;
    logic [3:0]        led_q, led_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        mem_q [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic              nonempty;

    // Next-state: display FSM, FIFO pointers/occupancy and overflow flag.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        pop      = 1'b0;

        // Pop decisions use the registered occupancy, so a nibble pushed this
        // cycle can never be the one popped this cycle.
        nonempty = (count_q != '0);
        full     = (count_q == DepthVal);

        unique case (state_q)
            StIdle: begin
                if (nonempty) begin
                    pop     = 1'b1;
                    hold_d  = HoldLoad;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (hold_q == '0) begin
                    if (nonempty) begin
                        pop    = 1'b1;
                        hold_d = HoldLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_d = hold_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            led_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        push = rx_done && (!full || pop);
        drop = rx_done && full && !pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            led_q    <= 4'b0000;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            led_q    <= led_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage has no reset; emptiness is defined by the pointers/count alone.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign led        = led_q;
    assign busy       = (state_q == StShow);
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule
